// File: rtl/pll_freq_monitor.sv
// pll_freq_monitor
// Counts rising edges of an asynchronous measured clock over a fixed window
// of system clocks, checks the count against an expected value, keeps a
// debounced lock status and a sticky fault for "PLL claims LOCKED while the
// measured frequency is out of range".
module pll_freq_monitor #(
    parameter int WINDOW         = 1000,
    parameter int EXPECTED       = 200,
    parameter int TOLERANCE      = 2,
    parameter int LOCK_WINDOWS   = 4,
    parameter int UNLOCK_WINDOWS = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 en,
    input  logic                 meas_clk,
    input  logic                 pll_locked,
    output logic [CNT_WIDTH-1:0] edge_count,
    output logic                 count_valid,
    output logic                 in_range,
    output logic                 locked,
    output logic                 fault
);

    localparam int WIN_W   = $clog2(WINDOW);
    localparam int RUN_MAX = (LOCK_WINDOWS > UNLOCK_WINDOWS) ? LOCK_WINDOWS : UNLOCK_WINDOWS;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [WIN_W-1:0]     WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [RUN_W-1:0]     RUN_SAT   = RUN_W'(RUN_MAX);
    localparam logic [RUN_W-1:0]     LOCK_THR  = RUN_W'(LOCK_WINDOWS);
    localparam logic [RUN_W-1:0]     UNLCK_THR = RUN_W'(UNLOCK_WINDOWS);
    // Lower bound clamps at zero so the unsigned compare never wraps.
    localparam logic [31:0] LO_BOUND = (EXPECTED > TOLERANCE) ? 32'(EXPECTED - TOLERANCE) : 32'd0;
    localparam logic [31:0] HI_BOUND = 32'(EXPECTED + TOLERANCE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic                 r_meas_s1;
    logic                 r_meas_s2;
    logic                 r_meas_hist;
    logic                 r_pll_s1;
    logic                 r_pll_s2;
    logic [WIN_W-1:0]     r_win_cnt;
    logic [CNT_WIDTH-1:0] r_edge_cnt;
    logic [RUN_W-1:0]     r_good_run;
    logic [RUN_W-1:0]     r_bad_run;
    logic [CNT_WIDTH-1:0] r_edge_count;
    logic                 r_count_valid;
    logic                 r_in_range;
    logic                 r_locked;
    logic                 r_fault;

    logic                 w_rise;
    logic                 w_terminal;
    logic                 w_close;
    logic [CNT_WIDTH-1:0] w_final;
    logic [31:0]          w_final_ext;
    logic                 w_in_range;
    logic [RUN_W-1:0]     w_good_next;
    logic [RUN_W-1:0]     w_bad_next;
    logic                 w_locked_next;

    // Saturating increment for the edge counter.
    function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v,
                                                         input logic inc);
        if (inc && (v != CNT_MAX)) begin
            return v + CNT_WIDTH'(1);
        end else begin
            return v;
        end
    endfunction

    // Saturating increment for the good/bad window run counters.
    function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
        if (v != RUN_SAT) begin
            return v + RUN_W'(1);
        end else begin
            return v;
        end
    endfunction

    assign w_rise      = r_meas_s2 & ~r_meas_hist;
    assign w_terminal  = (r_state != ST_IDLE) && (r_win_cnt == WIN_LAST);
    assign w_close     = (r_state == ST_MEASURE) && w_terminal;
    // A rise seen in the terminal cycle still belongs to the closing window.
    assign w_final     = sat_inc_cnt(r_edge_cnt, w_rise);
    assign w_final_ext = 32'(w_final);
    assign w_in_range  = (w_final_ext >= LO_BOUND) && (w_final_ext <= HI_BOUND);

    // Synchronize meas_clk and pll_locked into the clk domain, plus rise history.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_meas_s1   <= 1'b0;
            r_meas_s2   <= 1'b0;
            r_meas_hist <= 1'b0;
            r_pll_s1    <= 1'b0;
            r_pll_s2    <= 1'b0;
        end else begin
            r_meas_s1   <= meas_clk;
            r_meas_s2   <= r_meas_s1;
            r_meas_hist <= r_meas_s2;
            r_pll_s1    <= pll_locked;
            r_pll_s2    <= r_pll_s1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> SETTLE -> MEASURE, en low always returns to IDLE.
    always_comb begin
        w_next_state = r_state;
        if (!en) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_next_state = ST_SETTLE;
                ST_SETTLE:  w_next_state = w_terminal ? ST_MEASURE : ST_SETTLE;
                ST_MEASURE: w_next_state = ST_MEASURE;
                default:    w_next_state = ST_IDLE;
            endcase
        end
    end

    // Run-length update and lock decision for the window that is closing.
    always_comb begin
        w_good_next   = r_good_run;
        w_bad_next    = r_bad_run;
        w_locked_next = r_locked;
        if (w_in_range) begin
            w_good_next = sat_inc_run(r_good_run);
            w_bad_next  = {RUN_W{1'b0}};
        end else begin
            w_good_next = {RUN_W{1'b0}};
            w_bad_next  = sat_inc_run(r_bad_run);
        end
        if (w_good_next >= LOCK_THR) begin
            w_locked_next = 1'b1;
        end else if (w_bad_next >= UNLCK_THR) begin
            w_locked_next = 1'b0;
        end else begin
            w_locked_next = r_locked;
        end
    end

    // Window/edge counters and the registered results published at window close.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_win_cnt     <= {WIN_W{1'b0}};
            r_edge_cnt    <= {CNT_WIDTH{1'b0}};
            r_good_run    <= {RUN_W{1'b0}};
            r_bad_run     <= {RUN_W{1'b0}};
            r_edge_count  <= {CNT_WIDTH{1'b0}};
            r_count_valid <= 1'b0;
            r_in_range    <= 1'b0;
            r_locked      <= 1'b0;
            r_fault       <= 1'b0;
        end else if (!en) begin
            r_win_cnt     <= {WIN_W{1'b0}};
            r_edge_cnt    <= {CNT_WIDTH{1'b0}};
            r_good_run    <= {RUN_W{1'b0}};
            r_bad_run     <= {RUN_W{1'b0}};
            r_edge_count  <= {CNT_WIDTH{1'b0}};
            r_count_valid <= 1'b0;
            r_in_range    <= 1'b0;
            r_locked      <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_count_valid <= w_close;
            if ((r_state == ST_IDLE) || w_terminal) begin
                r_win_cnt  <= {WIN_W{1'b0}};
                r_edge_cnt <= {CNT_WIDTH{1'b0}};
            end else begin
                r_win_cnt  <= r_win_cnt + WIN_W'(1);
                r_edge_cnt <= w_final;
            end
            if (w_close) begin
                r_edge_count <= w_final;
                r_in_range   <= w_in_range;
                r_good_run   <= w_good_next;
                r_bad_run    <= w_bad_next;
                r_locked     <= w_locked_next;
                r_fault      <= r_fault | (~w_in_range & r_pll_s2);
            end
        end
    end

    assign edge_count  = r_edge_count;
    assign count_valid = r_count_valid;
    assign in_range    = r_in_range;
    assign locked      = r_locked;
    assign fault       = r_fault;

endmodule

// File: tb/tb_pll_freq_monitor.sv
// Bench for pll_freq_monitor: randomized meas_clk pulse trains per window,
// checked against a window-level model, on a default instance and on a
// CNT_WIDTH=4 instance that saturates every window.
module tb_pll_freq_monitor;

    localparam int W     = 1000;
    localparam int EXP   = 200;
    localparam int TOL   = 2;
    localparam int LOCKW = 4;
    localparam int UNLW  = 2;
    localparam int MAXK  = 12000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        meas_clk = 1'b0;
    logic        pll_locked = 1'b0;
    logic [15:0] edge_count;
    logic        count_valid, in_range, locked, fault;
    logic [3:0]  s_edge_count;
    logic        s_count_valid, s_in_range, s_locked, s_fault;

    pll_freq_monitor dut (
        .clk(clk), .RST(rst_n), .en(en), .meas_clk(meas_clk), .pll_locked(pll_locked),
        .edge_count(edge_count), .count_valid(count_valid), .in_range(in_range),
        .locked(locked), .fault(fault)
    );

    pll_freq_monitor #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .RST(rst_n), .en(en), .meas_clk(meas_clk), .pll_locked(pll_locked),
        .edge_count(s_edge_count), .count_valid(s_count_valid), .in_range(s_in_range),
        .locked(s_locked), .fault(s_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // meas_clk level for each drive cycle k (level seen by the first sync FF at edge k)
    bit lvl [0:MAXK-1];
    int win_n[$];

    // Window-level model, index 0 = default instance, 1 = 4-bit instance.
    int m_ec   [2];
    bit m_in   [2];
    bit m_lk   [2];
    bit m_ft   [2];
    int m_good [2];
    int m_bad  [2];
    int cmax   [2] = '{65535, 15};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_ec[i] = 0; m_in[i] = 0; m_lk[i] = 0; m_ft[i] = 0;
            m_good[i] = 0; m_bad[i] = 0;
        end
    endtask

    task automatic model_close(input int n);
        int lo;
        int c;
        lo = (EXP > TOL) ? EXP - TOL : 0;
        for (int i = 0; i < 2; i++) begin
            c = (n > cmax[i]) ? cmax[i] : n;
            m_ec[i] = c;
            m_in[i] = (c >= lo) && (c <= EXP + TOL);
            if (m_in[i]) begin m_good[i]++; m_bad[i] = 0; end
            else begin m_bad[i]++; m_good[i] = 0; end
            if (m_good[i] >= LOCKW) m_lk[i] = 1;
            else if (m_bad[i] >= UNLW) m_lk[i] = 0;
            if (!m_in[i] && pll_locked) m_ft[i] = 1;
        end
    endtask

    task automatic check_outputs(input bit vld);
        check_eq("valid",      int'(count_valid),   int'(vld));
        check_eq("edge_count", int'(edge_count),    m_ec[0]);
        check_eq("in_range",   int'(in_range),      int'(m_in[0]));
        check_eq("locked",     int'(locked),        int'(m_lk[0]));
        check_eq("fault",      int'(fault),         int'(m_ft[0]));
        check_eq("sat_valid",  int'(s_count_valid), int'(vld));
        check_eq("sat_count",  int'(s_edge_count),  m_ec[1]);
        check_eq("sat_range",  int'(s_in_range),    int'(m_in[1]));
        check_eq("sat_locked", int'(s_locked),      int'(m_lk[1]));
        check_eq("sat_fault",  int'(s_fault),       int'(m_ft[1]));
    endtask

    // n one-cycle pulses spread over [base, base+len-1], never merging with a
    // pulse that ends just before base.
    task automatic place(input int base, input int n, input int len, input bit at_end);
        int stride, maxoff, lo_off, off;
        if (n > 0) begin
            stride = len / n;
            maxoff = len - 1 - stride * (n - 1);
            lo_off = (base > 0 && lvl[base-1]) ? 1 : 0;
            off = at_end ? maxoff : int'($urandom_range(maxoff, lo_off));
            for (int i = 0; i < n; i++) lvl[base + off + i * stride] = 1'b1;
        end
    endtask

    // Rises whose count increment lands in measured window m.
    function automatic int bin_count(input int m);
        int lo, cnt;
        lo = (m + 1) * W - 1;
        cnt = 0;
        for (int k = lo; k < lo + W; k++) if (lvl[k] && !lvl[k-1]) cnt++;
        return cnt;
    endfunction

    // One enable session: settle noise + win_n windows; optional abort by en or reset.
    task automatic session(input bit pll, input int abort_at, input bit abort_rst, input bit ends);
        int nwin, last, c;
        bit vld;
        nwin = win_n.size();
        for (int k = 0; k < MAXK; k++) lvl[k] = 1'b0;
        place(1, int'($urandom_range(100, 0)), W - 4, 1'b0);
        for (int m = 0; m < nwin; m++) place((m + 1) * W - 1, win_n[m], W, ends && (m % 2 == 1));
        pll_locked = pll;
        en = 1'b1;
        c = 0;
        last = (abort_at >= 0) ? abort_at : (nwin + 1) * W + 3;
        while (c < last) begin
            @(posedge clk);
            vld = (c >= 2 * W) && (c % W == 0);
            if (vld) model_close(bin_count(c / W - 2));
            @(negedge clk);
            check_outputs(vld);
            meas_clk = lvl[c + 1];
            c++;
        end
        if (abort_rst) begin
            rst_n = 1'b0;
            #1;
            model_clear();
            check_outputs(1'b0);
            @(negedge clk);
            en = 1'b0;
            meas_clk = 1'b0;
            rst_n = 1'b1;
        end else begin
            en = 1'b0;
            meas_clk = 1'b0;
            @(posedge clk);
            @(negedge clk);
            model_clear();
            check_outputs(1'b0);
        end
        repeat (4) begin
            @(negedge clk);
            check_outputs(1'b0);
        end
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        check_outputs(1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Lock-in near nominal, PLL reports locked.
        win_n = '{200, 199, 201, 200, 200, 201};
        session(1'b1, -1, 1'b0, 1'b0);
        // Out of range high while PLL claims lock.
        win_n = '{210, 210, 211};
        session(1'b1, -1, 1'b0, 1'b0);
        // Lock, then half frequency: unlock after two bad windows.
        win_n = '{200, 200, 200, 200, 100, 100, 100};
        session(1'b0, -1, 1'b0, 1'b0);
        // Tolerance edges, with rises placed in the terminal cycle on odd windows.
        win_n = '{198, 202, 203, 202, 198, 197};
        session(1'b1, -1, 1'b0, 1'b1);
        // Abort by en mid-window, then by reset mid-window.
        win_n = '{200, 200};
        session(1'b1, 2 * W + 500, 1'b0, 1'b0);
        win_n = '{210, 210};
        session(1'b1, 2 * W + 400, 1'b1, 1'b0);
        // Randomized sessions around the tolerance band.
        repeat (2) begin
            win_n.delete();
            for (int i = 0; i < 6; i++) win_n.push_back(int'($urandom_range(205, 195)));
            session(1'(int'($urandom_range(1, 0))), -1, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_freq_monitor.md
# pll_freq_monitor

Synthesizable checker for the consuming side of a PLL output clock. It counts rising edges of an asynchronous measured clock, such as a CLKOUTn of the PLL model, over a fixed window of system clocks. It compares the count against an expected value and derives its own debounced lock status. It also flags a sticky fault if the PLL claims LOCKED while the measured frequency is out of range. It sits in benches and in hardware next to the PLL as an independent frequency and lock check.

## Interface
- WINDOW, 1000: window length in clk cycles; must be ≥ 4.
- EXPECTED, 200: expected rising edges of meas_clk per window.
- TOLERANCE, 2: in range when |count − EXPECTED| ≤ TOLERANCE.
- LOCK_WINDOWS, 4: consecutive in-range windows required to assert locked.
- UNLOCK_WINDOWS, 2: consecutive out-of-range windows required to deassert locked.
- CNT_WIDTH, 16: width of the edge counter and of edge_count.
- clk  input  1  system clock; all state is on its rising edge.
- RST  input  1  asynchronous, active-low reset (0 = reset).
- en  input  1  synchronous enable; low returns the block to IDLE.
- meas_clk  input  1  asynchronous measured clock; frequency must be < f(clk)/2.
- pll_locked  input  1  asynchronous LOCKED output of the PLL under check.
- edge_count  output  CNT_WIDTH  edge count of the last completed window.
- count_valid  output  1  one-cycle pulse when edge_count updates.
- in_range  output  1  range result of the last completed window.
- locked  output  1  debounced lock status of the monitor.
- fault  output  1  sticky: pll_locked was high at the end of an out-of-range window.

## Operation
- Input path: meas_clk goes through a 2-FF synchronizer, then a history FF. A rise is detected when sync=1 and history=0.
- pll_locked goes through its own 2-FF synchronizer.
- States:
  - IDLE: counters held at 0. Transition to SETTLE on the first clk with en=1.
  - SETTLE: runs one full window. The count is discarded and synchronizer history is flushed. Transition to MEASURE at the window end.
  - MEASURE: windows repeat back-to-back with no dead cycle.
- Window counter runs 0..WINDOW−1. The terminal cycle is when it equals WINDOW−1.
- Edge counter increments on each detected rise and saturates at 2^CNT_WIDTH−1.
- A rise detected in the terminal cycle belongs to the closing window. The new window starts its count at 0.
- At each MEASURE terminal cycle, on that clock edge:
  - edge_count ← final count.
  - in_range ← (EXPECTED−TOLERANCE ≤ count ≤ EXPECTED+TOLERANCE). Compare with unsigned arithmetic; a lower bound below 0 clamps to 0.
  - count_valid ← 1 for exactly one cycle.
  - good_run and bad_run update, both saturating: an in-range window increments good_run and clears bad_run; an out-of-range window does the reverse.
  - locked sets when good_run reaches LOCK_WINDOWS and clears when bad_run reaches UNLOCK_WINDOWS.
  - fault sets if the window is out of range and synchronized pll_locked = 1.
- fault clears only on reset or en low.
- en low at any point, including mid-window:
  - Next clk: state returns to IDLE.
  - Clears all counters, edge_count, count_valid, in_range, locked and fault.
- Reset mid-window gives the same result as en low, but applies immediately and asynchronously.

## Timing
- Reset values: edge_count=0, count_valid=0, in_range=0, locked=0, fault=0, state IDLE.
- meas_clk rise to edge counter increment: 3 clk edges (2 synchronizer + 1 detect).
- First count_valid after en rises: 2×WINDOW+1 clk cycles (1 entry cycle, SETTLE window, first MEASURE window).
- Later count_valid pulses come every WINDOW cycles exactly.
- locked rises with the count_valid of the LOCK_WINDOWS-th consecutive good window. It falls with the count_valid of the UNLOCK_WINDOWS-th consecutive bad window.
- in_range, locked and fault change only at count_valid cycles, except on reset or en low.
- pll_locked is sampled after its synchronizer. A change less than 2 clk cycles before a terminal cycle may be missed.

## Test plan
- Lock-in: clk 100 MHz, meas_clk 20 MHz, defaults, en=1 from t=0. Required: count_valid every 10 µs with edge_count 200±1, in_range=1, locked=1 at the 4th valid, fault=0.
- Out of range: meas_clk 21 MHz, pll_locked=1. Required: edge_count ≈210, in_range=0, locked stays 0, fault=1 at the first valid and stays set.
- Unlock debounce: lock at 20 MHz, then switch to 10 MHz. Required: edge_count ≈100; locked stays 1 after the first bad window and drops at the second; fault set only if pll_locked=1.
- Saturation: CNT_WIDTH=4, meas_clk 20 MHz. Required: edge_count=15 and in_range=0 every window.
- Abort: drop en mid-window, and separately pulse RST low mid-window. Required: all outputs return to reset values; re-enabling gives the first count_valid 2×WINDOW+1 cycles later.
- Boundary: meas_clk timed so counts are exactly 198, 202 and 203. Required: in_range = 1, 1, 0 respectively.
